// File: rtl/dof_pkg.sv
// Shared definitions for the operand-fetch stage: ctrl_in field layout and bypass selects.
package dof_pkg;

  // ctrl_in = {RW, DA, MD, BS, PS, MW, FS}, FS in the low bits
  localparam int RW_W = 1;
  localparam int DA_W = 5;
  localparam int MD_W = 2;
  localparam int BS_W = 2;
  localparam int PS_W = 1;
  localparam int MW_W = 1;
  localparam int FS_W = 5;
  localparam int SH_W = 5;

  localparam int FS_LSB = 0;
  localparam int MW_LSB = FS_LSB + FS_W;
  localparam int PS_LSB = MW_LSB + MW_W;
  localparam int BS_LSB = PS_LSB + PS_W;
  localparam int MD_LSB = BS_LSB + BS_W;
  localparam int DA_LSB = MD_LSB + MD_W;
  localparam int RW_LSB = DA_LSB + DA_W;
  localparam int CTRL_W = RW_LSB + RW_W;

  // MD value that marks an instruction as a load (write-back from memory)
  localparam logic [MD_W-1:0] MD_LOAD = 2'b01;

  typedef enum logic [1:0] {
    BYP_RF  = 2'd0,
    BYP_EXE = 2'd1,
    BYP_MEM = 2'd2
  } bypass_sel_e;

endpackage

// File: rtl/operand_bypass_mux.sv
// Picks one operand among EXE forward, MEM forward and register-file data.
module operand_bypass_mux
  import dof_pkg::*;
#(
  parameter int DATA_BITS = 32
) (
  input  bypass_sel_e          sel,
  input  logic [DATA_BITS-1:0] exe_data,
  input  logic [DATA_BITS-1:0] mem_data,
  input  logic [DATA_BITS-1:0] rf_data,
  output logic [DATA_BITS-1:0] operand
);

  always_comb begin
    operand = rf_data;
    unique case (sel)
      BYP_EXE: operand = exe_data;
      BYP_MEM: operand = mem_data;
      default: operand = rf_data;
    endcase
  end

endmodule

// File: rtl/operand_fetch_hazard_stage.sv
// Operand fetch stage: EXE/MEM forwarding, load-use bubble, valid/ready output register.
// Load-use stall logic and stall counter exist only when DOF_LOAD_USE_STALL_EN is defined.
module operand_fetch_hazard_stage
  import dof_pkg::*;
#(
  parameter int DATA_BITS        = 32,
  parameter int INSTRUCTION_BITS = 32,
  parameter int REG_ADDR_WIDTH   = 5,
  parameter int STALL_CNT_BITS   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [INSTRUCTION_BITS-1:0] instruction,
  input  logic [DATA_BITS-1:0]        pc_min_one,
  input  logic [CTRL_W-1:0]           ctrl_in,
  input  logic                        MA,
  input  logic                        MB,
  input  logic [REG_ADDR_WIDTH-1:0]   AA,
  input  logic [REG_ADDR_WIDTH-1:0]   BA,
  input  logic [DATA_BITS-1:0]        imm_ext,
  input  logic [DATA_BITS-1:0]        AData,
  input  logic [DATA_BITS-1:0]        BData,
  input  logic                        RW_EXE,
  input  logic [REG_ADDR_WIDTH-1:0]   DA_EXE,
  input  logic                        LD_EXE,
  input  logic [DATA_BITS-1:0]        fwd_exe_data,
  input  logic                        RW_MEM,
  input  logic [REG_ADDR_WIDTH-1:0]   DA_MEM,
  input  logic [DATA_BITS-1:0]        fwd_mem_data,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_BITS-1:0]        pc_min_two,
  output logic                        RW,
  output logic [DA_W-1:0]             DA,
  output logic [MD_W-1:0]             MD,
  output logic [BS_W-1:0]             BS,
  output logic [PS_W-1:0]             PS,
  output logic                        MW,
  output logic [FS_W-1:0]             FS,
  output logic [SH_W-1:0]             SH,
  output logic [DATA_BITS-1:0]        BUSA,
  output logic [DATA_BITS-1:0]        BUSB,
  output logic [STALL_CNT_BITS-1:0]   stall_cnt
);

  logic                 exe_live, mem_live;
  logic                 exe_hit_a, exe_hit_b, mem_hit_a, mem_hit_b;
  bypass_sel_e          sel_a, sel_b;
  logic [DATA_BITS-1:0] fwd_a, fwd_b, op_a, op_b;
  logic                 hazard, drain, take;
  logic                 rw_q, mw_q;
  logic                 unused_ok;

  // r0 is never a forwarding source even if a stage claims to write it
  assign exe_live  = RW_EXE && (DA_EXE != '0);
  assign mem_live  = RW_MEM && (DA_MEM != '0);
  assign exe_hit_a = exe_live && (DA_EXE == AA);
  assign exe_hit_b = exe_live && (DA_EXE == BA);
  assign mem_hit_a = mem_live && (DA_MEM == AA);
  assign mem_hit_b = mem_live && (DA_MEM == BA);

  assign sel_a = exe_hit_a ? BYP_EXE : (mem_hit_a ? BYP_MEM : BYP_RF);
  assign sel_b = exe_hit_b ? BYP_EXE : (mem_hit_b ? BYP_MEM : BYP_RF);

  operand_bypass_mux #(.DATA_BITS(DATA_BITS)) u_byp_a (
    .sel      (sel_a),
    .exe_data (fwd_exe_data),
    .mem_data (fwd_mem_data),
    .rf_data  (AData),
    .operand  (fwd_a)
  );

  operand_bypass_mux #(.DATA_BITS(DATA_BITS)) u_byp_b (
    .sel      (sel_b),
    .exe_data (fwd_exe_data),
    .mem_data (fwd_mem_data),
    .rf_data  (BData),
    .operand  (fwd_b)
  );

  assign op_a = MA ? pc_min_one : fwd_a;
  assign op_b = MB ? imm_ext    : fwd_b;

`ifdef DOF_LOAD_USE_STALL_EN
  // load result is not ready until MEM; a consumer in this stage must wait one cycle
  assign hazard = in_valid && LD_EXE && exe_live &&
                  ((exe_hit_a && !MA) || (exe_hit_b && !MB));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (hazard && !flush && !(&stall_cnt))
      stall_cnt <= stall_cnt + STALL_CNT_BITS'(1);
  end

  assign unused_ok = ^instruction[INSTRUCTION_BITS-1:SH_W];
`else
  assign hazard    = 1'b0;
  assign stall_cnt = '0;
  assign unused_ok = ^{instruction[INSTRUCTION_BITS-1:SH_W], LD_EXE};
`endif

  assign drain    = !out_valid || out_ready;
  assign in_ready = drain && !hazard && !flush;
  assign take     = in_valid && in_ready;

  // hazard with a free downstream falls into the drain branch, producing the bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      pc_min_two <= '0;
      rw_q       <= 1'b0;
      DA         <= '0;
      MD         <= '0;
      BS         <= '0;
      PS         <= '0;
      mw_q       <= 1'b0;
      FS         <= '0;
      SH         <= '0;
      BUSA       <= '0;
      BUSB       <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (take) begin
      out_valid  <= 1'b1;
      pc_min_two <= pc_min_one;
      rw_q       <= ctrl_in[RW_LSB];
      DA         <= ctrl_in[DA_LSB +: DA_W];
      MD         <= ctrl_in[MD_LSB +: MD_W];
      BS         <= ctrl_in[BS_LSB +: BS_W];
      PS         <= ctrl_in[PS_LSB +: PS_W];
      mw_q       <= ctrl_in[MW_LSB];
      FS         <= ctrl_in[FS_LSB +: FS_W];
      SH         <= instruction[SH_W-1:0];
      BUSA       <= op_a;
      BUSB       <= op_b;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

  // side-effecting strobes must never leak out of an empty slot
  assign RW = rw_q && out_valid;
  assign MW = mw_q && out_valid;

endmodule

// File: tb/tb_operand_fetch_hazard_stage.sv
// Randomized and directed bench for operand_fetch_hazard_stage against a cycle-level model.
module tb_operand_fetch_hazard_stage;
  import dof_pkg::*;

  localparam int DW = 32;
  localparam int IW = 32;
  localparam int AW = 5;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [IW-1:0] instruction;
  logic [DW-1:0] pc_min_one;
  logic [CTRL_W-1:0] ctrl_in;
  logic          MA, MB;
  logic [AW-1:0] AA, BA;
  logic [DW-1:0] imm_ext, AData, BData;
  logic          RW_EXE, LD_EXE;
  logic [AW-1:0] DA_EXE;
  logic [DW-1:0] fwd_exe_data;
  logic          RW_MEM;
  logic [AW-1:0] DA_MEM;
  logic [DW-1:0] fwd_mem_data;
  logic          flush;
  logic          out_valid, out_ready;
  logic [DW-1:0] pc_min_two;
  logic          RW, MW;
  logic [DA_W-1:0] DA;
  logic [MD_W-1:0] MD;
  logic [BS_W-1:0] BS;
  logic [PS_W-1:0] PS;
  logic [FS_W-1:0] FS;
  logic [SH_W-1:0] SH;
  logic [DW-1:0] BUSA, BUSB;
  logic [SW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // model state: contents of the output slot as seen by downstream
  logic          m_valid;
  logic [DW-1:0] m_busa, m_busb, m_pc;
  logic [CTRL_W-1:0] m_ctrl;
  logic [SH_W-1:0] m_sh;
  logic [SW-1:0] m_stall;

  operand_fetch_hazard_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .pc_min_one(pc_min_one), .ctrl_in(ctrl_in),
    .MA(MA), .MB(MB), .AA(AA), .BA(BA), .imm_ext(imm_ext), .AData(AData), .BData(BData),
    .RW_EXE(RW_EXE), .DA_EXE(DA_EXE), .LD_EXE(LD_EXE), .fwd_exe_data(fwd_exe_data),
    .RW_MEM(RW_MEM), .DA_MEM(DA_MEM), .fwd_mem_data(fwd_mem_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .pc_min_two(pc_min_two),
    .RW(RW), .DA(DA), .MD(MD), .BS(BS), .PS(PS), .MW(MW), .FS(FS), .SH(SH),
    .BUSA(BUSA), .BUSB(BUSB), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t, limit 5000000", $time);
    $fatal(1);
  end

  // newest writer wins; r0 never forwarded
  function automatic logic [DW-1:0] src_value(input logic [AW-1:0] src, input logic [DW-1:0] rf);
    if (RW_EXE && DA_EXE != 0 && DA_EXE == src) return fwd_exe_data;
    if (RW_MEM && DA_MEM != 0 && DA_MEM == src) return fwd_mem_data;
    return rf;
  endfunction

  function automatic logic m_hazard();
`ifdef DOF_LOAD_USE_STALL_EN
    return in_valid && LD_EXE && RW_EXE && DA_EXE != 0 &&
           ((DA_EXE == AA && !MA) || (DA_EXE == BA && !MB));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic m_ready();
    return (!m_valid || out_ready) && !m_hazard() && !flush;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_busa = 0; m_busb = 0; m_pc = 0; m_ctrl = 0; m_sh = 0; m_stall = 0;
  endtask

  task automatic model_edge();
    logic hz, acc;
    hz  = m_hazard();
    acc = in_valid && m_ready();
    if (flush) m_valid = 0;
    else if (acc) begin
      m_valid = 1;
      m_busa  = MA ? pc_min_one : src_value(AA, AData);
      m_busb  = MB ? imm_ext : src_value(BA, BData);
      m_pc    = pc_min_one;
      m_ctrl  = ctrl_in;
      m_sh    = instruction[SH_W-1:0];
    end else if (!m_valid || out_ready) m_valid = 0;
    if (hz && !flush && m_stall != {SW{1'b1}}) m_stall = m_stall + 16'd1;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    in_valid = 0; flush = 0; out_ready = 1; instruction = 0; pc_min_one = 0; ctrl_in = 0;
    MA = 0; MB = 0; AA = 0; BA = 0; imm_ext = 0; AData = 0; BData = 0;
    RW_EXE = 0; DA_EXE = 0; LD_EXE = 0; fwd_exe_data = 0;
    RW_MEM = 0; DA_MEM = 0; fwd_mem_data = 0;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 0;
    #12;
    checks++;
    if ({out_valid, RW, MW, BUSA, BUSB, pc_min_two, DA, MD, BS, PS, FS, SH, stall_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b busa=%h busb=%h pc=%h stall=%h, want all zero",
               out_valid, BUSA, BUSB, pc_min_two, stall_cnt);
    end
    @(negedge clk);
    rst_n = 1;
    model_reset();
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_forwarding();
    set_idle();
    in_valid = 1; ctrl_in = CTRL_W'($urandom);
    AA = 3; RW_EXE = 1; DA_EXE = 3; fwd_exe_data = 32'hAAAA;
    RW_MEM = 1; DA_MEM = 3; fwd_mem_data = 32'h5555; AData = 32'h1111;
    BA = 9; BData = 32'h2222;
    tick();
    checks++;
    if (out_valid !== 1'b1 || BUSA !== 32'hAAAA) begin
      errors++; $display("FAIL fwd_exe_priority: valid=%b busa=%h want 1/0000aaaa", out_valid, BUSA);
    end
    checks++;
    if (BUSB !== 32'h2222) begin errors++; $display("FAIL fwd_b_rf: got %h want 00002222", BUSB); end
    DA_EXE = 4; BA = 4; fwd_exe_data = 32'hBEEF;
    tick();
    checks++;
    if (BUSA !== 32'h5555 || BUSB !== 32'hBEEF) begin
      errors++; $display("FAIL fwd_mem_and_b_exe: busa=%h busb=%h want 00005555/0000beef", BUSA, BUSB);
    end
    MA = 1; pc_min_one = 32'h100; MB = 1; imm_ext = 32'h77;
    tick();
    checks++;
    if (BUSA !== 32'h100 || BUSB !== 32'h77 || pc_min_two !== 32'h100) begin
      errors++; $display("FAIL pc_imm_select: busa=%h busb=%h pc2=%h want 100/77/100", BUSA, BUSB, pc_min_two);
    end
    MA = 0; MB = 0; AA = 0; DA_EXE = 0; RW_EXE = 1; fwd_exe_data = 32'hDEAD;
    DA_MEM = 0; RW_MEM = 1; AData = 32'h1234;
    tick();
    checks++;
    if (BUSA !== 32'h1234) begin errors++; $display("FAIL r0_no_forward: got %h want 00001234", BUSA); end
  endtask

  task automatic test_load_use();
    logic [SW-1:0] s0;
    set_idle();
    in_valid = 1;
    tick();
    AA = 1; BA = 7; MB = 0; BData = 32'hBBBB;
    LD_EXE = 1; RW_EXE = 1; DA_EXE = 7; fwd_exe_data = 32'hEEEE;
    s0 = m_stall;
    #1;
`ifdef DOF_LOAD_USE_STALL_EN
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_in_ready: got %b want 0", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b0 || stall_cnt !== s0 + 16'd1) begin
      errors++; $display("FAIL lu_bubble: valid=%b stall=%0d want 0/%0d", out_valid, stall_cnt, s0 + 16'd1);
    end
    LD_EXE = 0; RW_EXE = 0; RW_MEM = 1; DA_MEM = 7; fwd_mem_data = 32'h7777;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_release: got %b want 1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || BUSB !== 32'h7777 || stall_cnt !== s0 + 16'd1) begin
      errors++; $display("FAIL lu_issue: valid=%b busb=%h stall=%0d want 1/7777/%0d",
                         out_valid, BUSB, stall_cnt, s0 + 16'd1);
    end
`else
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_no_stall: got %b want 1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || BUSB !== 32'hEEEE || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL lu_no_stall_issue: valid=%b busb=%h stall=%0d want 1/eeee/0",
                         out_valid, BUSB, stall_cnt);
    end
`endif
  endtask

  task automatic test_backpressure();
    logic [CTRL_W-1:0] c1;
    set_idle();
    in_valid = 1; AData = 32'h1000; pc_min_one = 32'h40; c1 = CTRL_W'($urandom); ctrl_in = c1;
    tick();
    out_ready = 0; AData = 32'h2000; pc_min_one = 32'h44; ctrl_in = ~c1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || BUSA !== 32'h1000 || pc_min_two !== 32'h40 || FS !== c1[FS_LSB +: FS_W]) begin
        errors++; $display("FAIL bp_hold[%0d]: valid=%b busa=%h pc2=%h fs=%h want 1/1000/40/%h",
                           i, out_valid, BUSA, pc_min_two, FS, c1[FS_LSB +: FS_W]);
      end
    end
    out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || BUSA !== 32'h2000 || pc_min_two !== 32'h44) begin
      errors++; $display("FAIL bp_next: valid=%b busa=%h pc2=%h want 1/2000/44", out_valid, BUSA, pc_min_two);
    end
  endtask

  task automatic test_flush_and_reset();
    set_idle();
    in_valid = 1;
    ctrl_in = '0; ctrl_in[RW_LSB] = 1'b1; ctrl_in[MW_LSB] = 1'b1;
    tick();
    checks++;
    if (RW !== 1'b1 || MW !== 1'b1) begin errors++; $display("FAIL strobes_valid: rw=%b mw=%b want 1/1", RW, MW); end
    flush = 1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b0 || RW !== 1'b0 || MW !== 1'b0) begin
      errors++; $display("FAIL flush_clear: valid=%b rw=%b mw=%b want 0/0/0", out_valid, RW, MW);
    end
    flush = 0; AData = 32'h55; BA = 6; LD_EXE = 1; RW_EXE = 1; DA_EXE = 6;
    tick();
    tick();
    #2;
    rst_n = 0;
    #1;
    checks++;
    if ({out_valid, RW, MW, BUSA, BUSB, pc_min_two, DA, MD, BS, PS, FS, SH, stall_cnt} !== '0) begin
      errors++; $display("FAIL async_reset: valid=%b busa=%h busb=%h stall=%h want all zero",
                         out_valid, BUSA, BUSB, stall_cnt);
    end
    set_idle();
    model_reset();
    @(negedge clk);
    rst_n = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset: in_ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 15) == 0);
      instruction = IW'($urandom); pc_min_one = DW'($urandom); ctrl_in = CTRL_W'($urandom);
      MA = ($urandom_range(0, 3) == 0); MB = ($urandom_range(0, 3) == 0);
      AA = AW'($urandom_range(0, 3)); BA = AW'($urandom_range(0, 3));
      imm_ext = DW'($urandom); AData = DW'($urandom); BData = DW'($urandom);
      RW_EXE = 1'($urandom); LD_EXE = ($urandom_range(0, 2) == 0); DA_EXE = AW'($urandom_range(0, 3));
      fwd_exe_data = DW'($urandom);
      RW_MEM = 1'($urandom); DA_MEM = AW'($urandom_range(0, 3)); fwd_mem_data = DW'($urandom);
      #1;
      checks++;
      if (in_ready !== m_ready()) begin
        errors++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", n, in_ready, m_ready());
      end
      tick();
      checks++;
      if (out_valid !== m_valid || RW !== (m_valid & m_ctrl[RW_LSB]) || MW !== (m_valid & m_ctrl[MW_LSB]) ||
          stall_cnt !== m_stall) begin
        errors++; $display("FAIL rnd_ctl[%0d]: valid=%b rw=%b mw=%b stall=%0d want %b/%b/%b/%0d", n,
                           out_valid, RW, MW, stall_cnt, m_valid, m_valid & m_ctrl[RW_LSB],
                           m_valid & m_ctrl[MW_LSB], m_stall);
      end
      if (m_valid) begin
        checks++;
        if ({BUSA, BUSB, pc_min_two, DA, MD, BS, PS, FS, SH} !==
            {m_busa, m_busb, m_pc, m_ctrl[DA_LSB +: DA_W], m_ctrl[MD_LSB +: MD_W], m_ctrl[BS_LSB +: BS_W],
             m_ctrl[PS_LSB +: PS_W], m_ctrl[FS_LSB +: FS_W], m_sh}) begin
          errors++; $display("FAIL rnd_data[%0d]: busa=%h busb=%h pc2=%h want %h/%h/%h", n,
                             BUSA, BUSB, pc_min_two, m_busa, m_busb, m_pc);
        end
      end
    end
  endtask

  task automatic test_saturate();
    set_idle();
    in_valid = 1; AA = 2; LD_EXE = 1; RW_EXE = 1; DA_EXE = 2;
    repeat ((1 << SW) + 2) tick();
    checks++;
    if (stall_cnt !== 16'hFFFF || in_ready !== 1'b0) begin
      errors++; $display("FAIL stall_saturate: stall=%h in_ready=%b want ffff/0", stall_cnt, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_backpressure();
    test_flush_and_reset();
    test_random();
`ifdef DOF_LOAD_USE_STALL_EN
    test_saturate();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
